// File: rtl/glyph_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glyph_pkg : shared widths, screen geometry and FSM encoding for the blitter
// Revision  : 1.0
// ---------------------------------------------------------------------------
package glyph_pkg;

  localparam int CHAR_ID_WIDTH  = 8;
  localparam int X_WIDTH        = 9;
  localparam int Y_WIDTH        = 9;
  localparam int COLOR_WIDTH    = 4;
  localparam int FB_ADDR_WIDTH  = 17;
  localparam int GLYPH_W        = 8;
  localparam int GLYPH_H        = 8;
  localparam int SCREEN_W       = 320;
  localparam int SCREEN_H       = 240;

  localparam int ROW_W          = $clog2(GLYPH_H);
  localparam int COL_W          = $clog2(GLYPH_W);
  localparam int ROM_ADDR_WIDTH = CHAR_ID_WIDTH + ROW_W;
  // One bit wider than the coordinates so clipping never wraps
  localparam int XS_W           = X_WIDTH + 1;
  localparam int YS_W           = Y_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WAIT_ROM = 3'd3,
    ST_DRAW     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fb_address_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_address_gen : pixel position, clip flag and linear framebuffer address
// Revision       : 1.0
// ---------------------------------------------------------------------------
module fb_address_gen
  import glyph_pkg::*;
(
  input  logic [X_WIDTH-1:0]       x_i,
  input  logic [Y_WIDTH-1:0]       y_i,
  input  logic [COL_W-1:0]         col_i,
  input  logic [ROW_W-1:0]         row_i,
  output logic                     in_bounds_o,
  output logic [FB_ADDR_WIDTH-1:0] fb_addr_o
);

  localparam int PROD_W = YS_W + $clog2(SCREEN_W) + 1;

  logic [XS_W-1:0]   w_px;
  logic [YS_W-1:0]   w_py;
  logic [PROD_W-1:0] w_lin;

  assign w_px        = {1'b0, x_i} + XS_W'(col_i);
  assign w_py        = {1'b0, y_i} + YS_W'(row_i);
  assign in_bounds_o = (w_px < XS_W'(SCREEN_W)) && (w_py < YS_W'(SCREEN_H));

  // Constant multiplier; 320 reduces to (py << 8) + (py << 6)
  assign w_lin     = PROD_W'(w_py) * PROD_W'(SCREEN_W) + PROD_W'(w_px);
  assign fb_addr_o = w_lin[FB_ADDR_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/glyph_blitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glyph_blitter : pops (id, x, y) entries and rasterises 8x8 glyphs to the FB
// Revision      : 1.0
// ---------------------------------------------------------------------------
module glyph_blitter
  import glyph_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      empty,
  output logic                      pop,
  input  logic [CHAR_ID_WIDTH-1:0]  character_id,
  input  logic [X_WIDTH-1:0]        x_in,
  input  logic [Y_WIDTH-1:0]        y_in,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [GLYPH_W-1:0]        rom_data,
  input  logic [COLOR_WIDTH-1:0]    fg_color,
  output logic                      fb_we,
  output logic [FB_ADDR_WIDTH-1:0]  fb_addr,
  output logic [COLOR_WIDTH-1:0]    fb_data,
  input  logic                      fb_ready,
  output logic                      idle
);

  state_t                     state_q, state_d;
  logic [CHAR_ID_WIDTH-1:0]   id_q, id_d;
  logic [X_WIDTH-1:0]         x_q, x_d;
  logic [Y_WIDTH-1:0]         y_q, y_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [GLYPH_W-1:0]         shift_q, shift_d;

  logic                       w_pop;
  logic                       w_we;
  logic                       w_pix;
  logic                       w_in_bounds;
  logic [FB_ADDR_WIDTH-1:0]   w_addr;

  fb_address_gen u_addr_gen (
    .x_i         (x_q),
    .y_i         (y_q),
    .col_i       (col_q),
    .row_i       (row_q),
    .in_bounds_o (w_in_bounds),
    .fb_addr_o   (w_addr)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      col_q   <= col_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    col_d   = col_q;
    shift_d = shift_q;
    w_pop   = 1'b0;
    w_we    = 1'b0;
    w_pix   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && !empty) begin
          w_pop   = 1'b1;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        id_d    = character_id;
        x_d     = x_in;
        y_d     = y_in;
        row_d   = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_WAIT_ROM;
      end
      ST_WAIT_ROM: begin
        shift_d = rom_data;
        col_d   = '0;
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        // The shifter's MSB is always the pixel at the current column
        w_pix = shift_q[GLYPH_W-1] && w_in_bounds;
        w_we  = w_pix;
        if (!w_pix || fb_ready) begin
          shift_d = shift_q << 1;
          if (col_q == COL_W'(GLYPH_W - 1)) begin
            if (row_q == ROW_W'(GLYPH_H - 1)) begin
              state_d = ST_IDLE;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = ST_FETCH;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are masked during reset so an interrupted glyph cannot write again
  assign pop      = w_pop && reset_n;
  assign fb_we    = w_we && reset_n;
  assign fb_addr  = fb_we ? w_addr : '0;
  assign fb_data  = fb_we ? fg_color : '0;
  assign rom_addr = {id_q, row_q};
  assign idle     = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_glyph_blitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_glyph_blitter : directed self-checking bench for glyph_blitter
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_glyph_blitter;
  import glyph_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic                      enable;
  logic                      empty;
  logic                      pop;
  logic [CHAR_ID_WIDTH-1:0]  character_id;
  logic [X_WIDTH-1:0]        x_in;
  logic [Y_WIDTH-1:0]        y_in;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [GLYPH_W-1:0]        rom_data;
  logic [COLOR_WIDTH-1:0]    fg_color;
  logic                      fb_we;
  logic [FB_ADDR_WIDTH-1:0]  fb_addr;
  logic [COLOR_WIDTH-1:0]    fb_data;
  logic                      fb_ready;
  logic                      idle;

  always #5 clock = ~clock;

  glyph_blitter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .empty        (empty),
    .pop          (pop),
    .character_id (character_id),
    .x_in         (x_in),
    .y_in         (y_in),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .fg_color     (fg_color),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_ready     (fb_ready),
    .idle         (idle)
  );

  // Entry store: the initial block owns wr_ptr, the pop model owns rd_ptr
  logic [7:0] s_id [0:15];
  logic [8:0] s_x  [0:15];
  logic [8:0] s_y  [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         cyc    = 0;
  logic [7:0] rom [0:2047];

  assign empty = (rd_ptr == wr_ptr);

  always @(posedge clock) begin
    if (pop) begin
      character_id <= s_id[rd_ptr[3:0]];
      x_in         <= s_x[rd_ptr[3:0]];
      y_in         <= s_y[rd_ptr[3:0]];
      rd_ptr       <= rd_ptr + 1;
    end
    rom_data <= rom[rom_addr];
    cyc      <= cyc + 1;
  end

  logic [16:0] wl_addr [$];
  logic [3:0]  wl_data [$];
  int          pop_cyc [$];
  int          viol     = 0;
  bit          prev_pop = 1'b0;

  always @(negedge clock) begin
    if (fb_we && fb_ready) begin
      wl_addr.push_back(fb_addr);
      wl_data.push_back(fb_data);
    end
    if (pop) begin
      pop_cyc.push_back(cyc);
      if (prev_pop) viol++;
      if (empty) viol++;
    end
    prev_pop = pop;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drv();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] id, input logic [8:0] x, input logic [8:0] y);
    s_id[wr_ptr[3:0]] = id;
    s_x[wr_ptr[3:0]]  = x;
    s_y[wr_ptr[3:0]]  = y;
    wr_ptr++;
  endtask

  // Runs one already-queued glyph; optionally stalls its first write 3 cycles
  task automatic run_glyph(input string tag, input bit stall, output int dur);
    int  n;
    int  pc;
    bit  stalled;
    fb_ready = !stall;
    enable   = 1'b1;
    n = 0;
    smp();
    while (!pop && n < 50) begin
      smp();
      n++;
    end
    chk({tag, "_pop"}, 32'(pop), 32'd1);
    pc      = cyc;
    stalled = 1'b0;
    n       = 0;
    do begin
      smp();
      n++;
      if (stall && !stalled && fb_we) begin
        stalled = 1'b1;
        repeat (2) begin
          smp();
          chk({tag, "_hold"}, 32'({fb_we, fb_addr, fb_data}), 32'({1'b1, 17'd6410, fg_color}));
        end
        drv();
        fb_ready = 1'b1;
        smp();
        chk({tag, "_hold"}, 32'({fb_we, fb_addr, fb_data}), 32'({1'b1, 17'd6410, fg_color}));
      end
    end while (!idle && n < 300);
    dur = cyc - pc;
  endtask

  initial begin
    int dur;
    int wb;
    int pb;
    int n;

    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    rom[{8'h41, 3'd0}] = 8'h81;
    rom[{8'h42, 3'd0}] = 8'h80;
    rom[{8'h43, 3'd7}] = 8'h01;
    for (int r = 0; r < 8; r++) begin
      rom[{8'h07, 3'(r)}] = 8'hFF;
      rom[{8'h44, 3'(r)}] = 8'hFF;
    end

    reset_n  = 1'b0;
    enable   = 1'b0;
    fb_ready = 1'b1;
    fg_color = 4'hA;
    repeat (3) drv();
    smp();
    chk("rst_pop",      32'(pop),      32'd0);
    chk("rst_fb_we",    32'(fb_we),    32'd0);
    chk("rst_fb_addr",  32'(fb_addr),  32'd0);
    chk("rst_fb_data",  32'(fb_data),  32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_idle",     32'(idle),     32'd1);
    drv();
    reset_n = 1'b1;

    // Single glyph, two set pixels on row 0
    push(8'h41, 9'd10, 9'd20);
    wb = wl_addr.size();
    run_glyph("single", 1'b0, dur);
    chk("single_dur",   32'(dur), 32'd82);
    chk("single_count", 32'(wl_addr.size() - wb), 32'd2);
    if (wl_addr.size() - wb == 2) begin
      chk("single_addr0", 32'(wl_addr[wb]),     32'd6410);
      chk("single_addr1", 32'(wl_addr[wb + 1]), 32'd6417);
      chk("single_data0", 32'(wl_data[wb]),     32'hA);
      chk("single_data1", 32'(wl_data[wb + 1]), 32'hA);
    end

    // Clipping at the bottom-right corner
    drv();
    push(8'h07, 9'd316, 9'd236);
    wb = wl_addr.size();
    run_glyph("clip", 1'b0, dur);
    chk("clip_dur",   32'(dur), 32'd82);
    chk("clip_count", 32'(wl_addr.size() - wb), 32'd16);
    if (wl_addr.size() - wb == 16) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          chk("clip_addr", 32'(wl_addr[wb + r * 4 + c]), 32'((236 + r) * 320 + 316 + c));
    end

    // Backpressure on the first write
    drv();
    push(8'h41, 9'd10, 9'd20);
    wb = wl_addr.size();
    run_glyph("bp", 1'b1, dur);
    chk("bp_dur",   32'(dur), 32'd85);
    chk("bp_count", 32'(wl_addr.size() - wb), 32'd2);
    if (wl_addr.size() - wb == 2) begin
      chk("bp_addr0", 32'(wl_addr[wb]),     32'd6410);
      chk("bp_addr1", 32'(wl_addr[wb + 1]), 32'd6417);
    end

    // Enabled but empty: no pops
    pb = pop_cyc.size();
    repeat (100) smp();
    chk("empty_nopop", 32'(pop_cyc.size() - pb), 32'd0);

    // Enable dropped mid-glyph with two entries queued
    drv();
    enable = 1'b0;
    push(8'h41, 9'd10, 9'd20);
    push(8'h41, 9'd30, 9'd40);
    pb = pop_cyc.size();
    wb = wl_addr.size();
    drv();
    enable = 1'b1;
    n = 0;
    smp();
    while (!pop && n < 50) begin smp(); n++; end
    chk("en_pop", 32'(pop), 32'd1);
    repeat (20) smp();
    drv();
    enable = 1'b0;
    n = 0;
    do begin smp(); n++; end while (!idle && n < 300);
    repeat (100) smp();
    chk("en_pops",   32'(pop_cyc.size() - pb), 32'd1);
    chk("en_writes", 32'(wl_addr.size() - wb), 32'd2);
    chk("en_left",   32'(empty), 32'd0);
    drv();
    wr_ptr = rd_ptr;

    // Back-to-back glyphs
    push(8'h41, 9'd0,   9'd0);
    push(8'h42, 9'd100, 9'd50);
    push(8'h43, 9'd200, 9'd100);
    pb = pop_cyc.size();
    wb = wl_addr.size();
    enable = 1'b1;
    n = 0;
    do begin smp(); n++; end while (!(idle && empty && pop_cyc.size() - pb == 3) && n < 400);
    chk("b2b_pops", 32'(pop_cyc.size() - pb), 32'd3);
    if (pop_cyc.size() - pb == 3) begin
      chk("b2b_gap0", 32'(pop_cyc[pb + 1] - pop_cyc[pb]),     32'd82);
      chk("b2b_gap1", 32'(pop_cyc[pb + 2] - pop_cyc[pb + 1]), 32'd82);
    end
    chk("b2b_count", 32'(wl_addr.size() - wb), 32'd4);
    if (wl_addr.size() - wb == 4) begin
      chk("b2b_addr0", 32'(wl_addr[wb]),     32'd0);
      chk("b2b_addr1", 32'(wl_addr[wb + 1]), 32'd7);
      chk("b2b_addr2", 32'(wl_addr[wb + 2]), 32'd16100);
      chk("b2b_addr3", 32'(wl_addr[wb + 3]), 32'd34447);
    end

    // Reset pulse in the middle of row 3
    drv();
    fg_color = 4'h5;
    push(8'h44, 9'd0,  9'd0);
    push(8'h41, 9'd10, 9'd20);
    n = 0;
    smp();
    while (!(fb_we && fb_addr == 17'd962) && n < 200) begin smp(); n++; end
    chk("rst_mid_reach", 32'(fb_addr), 32'd962);
    drv();
    reset_n = 1'b0;
    wb = wl_addr.size();
    smp();
    chk("rst_mid_we_low", 32'(fb_we), 32'd0);
    drv();
    reset_n = 1'b1;
    smp();
    chk("rst_after_we",   32'(fb_we), 32'd0);
    chk("rst_after_idle", 32'(idle),  32'd1);
    chk("rst_after_pop",  32'(pop),   32'd1);
    n = 0;
    do begin smp(); n++; end while (!idle && n < 300);
    chk("rst_writes", 32'(wl_addr.size() - wb), 32'd2);
    if (wl_addr.size() - wb == 2) begin
      chk("rst_addr0", 32'(wl_addr[wb]),     32'd6410);
      chk("rst_addr1", 32'(wl_addr[wb + 1]), 32'd6417);
      chk("rst_data0", 32'(wl_data[wb]),     32'h5);
    end

    chk("pop_rules", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glyph_blitter.md
# glyph_blitter

Downstream consumer of the character stack buffer. Pops `(character_id, x, y)` entries while the stack is non-empty and rasterises each 8×8 glyph from an external glyph ROM into the framebuffer write port. Set glyph pixels get the foreground colour; clear pixels are transparent. Pixels outside the screen are clipped.

## Interface
- `CHAR_ID_WIDTH`, 8: character id width
- `X_WIDTH`, 9: x coordinate width
- `Y_WIDTH`, 9: y coordinate width
- `GLYPH_W`, 8: glyph width in pixels, one ROM word per row
- `GLYPH_H`, 8: glyph height in rows
- `SCREEN_W`, 320: visible width
- `SCREEN_H`, 240: visible height
- `COLOR_WIDTH`, 4: framebuffer pixel width
- `FB_ADDR_WIDTH`, 17: framebuffer address width
- `clock`  in  1  single clock; all logic on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `enable`  in  1  allows new pops; an in-progress glyph always completes
- `empty`  in  1  stack empty flag
- `pop`  out  1  one-cycle pop strobe to the stack
- `character_id`  in  CHAR_ID_WIDTH  popped id, valid the cycle after `pop`
- `x_in`  in  X_WIDTH  popped glyph left edge, valid the cycle after `pop`
- `y_in`  in  Y_WIDTH  popped glyph top edge, valid the cycle after `pop`
- `rom_addr`  out  CHAR_ID_WIDTH+$clog2(GLYPH_H)  `{character_id, row}`
- `rom_data`  in  GLYPH_W  row bitmap, valid one cycle after `rom_addr`; MSB = leftmost pixel
- `fg_color`  in  COLOR_WIDTH  colour written for set pixels
- `fb_we`  out  1  framebuffer write strobe
- `fb_addr`  out  FB_ADDR_WIDTH  `(y+row)*SCREEN_W + (x+col)`
- `fb_data`  out  COLOR_WIDTH  pixel value
- `fb_ready`  in  1  framebuffer accepts the write this cycle
- `idle`  out  1  high only in IDLE

## Operation
- FSM states: IDLE, LATCH, FETCH, WAIT_ROM, DRAW.
- **IDLE**
  - If `enable & ~empty`: assert `pop` for one cycle and go to LATCH.
  - Otherwise stay in IDLE.
- **LATCH:** register `character_id`, `x_in`, `y_in`; set row = 0; go to FETCH.
- **FETCH:** drive `rom_addr = {id, row}`; go to WAIT_ROM.
- **WAIT_ROM:** register `rom_data` into the row shifter; set col = 0; go to DRAW.
- **DRAW:** one column per cycle.
  - A pixel is writable when `bit[GLYPH_W-1-col]` is set, `x+col < SCREEN_W` and `y+row < SCREEN_H`.
  - Writable pixel: drive `fb_we=1`, `fb_addr`, `fb_data=fg_color`. Hold all three, and col, until `fb_ready`.
  - Non-writable pixel: `fb_we=0`; advance col without waiting.
  - After the last column:
    - row < GLYPH_H-1: row++ and go to FETCH.
    - Otherwise go to IDLE.
- **Coordinate arithmetic:** `x+col` and `y+row` are computed 1 bit wider than their operands, so clipping never wraps. `fb_addr` is truncated to FB_ADDR_WIDTH and is only meaningful when `fb_we=1`.
- **`fg_color`:** sampled at each write, not latched per glyph.
- **`enable` low mid-glyph:** the current glyph finishes, then the block parks in IDLE.
- **`empty` rising while busy:** ignored until IDLE.
- **Reset (asserted any cycle):** next state IDLE; current glyph dropped with no further writes; no pop is reissued.

## Timing
- Reset values: `pop=0`, `fb_we=0`, `fb_addr=0`, `fb_data=0`, `rom_addr=0`, `idle=1`, state IDLE.
- `pop` is never asserted in two consecutive cycles and never while `empty=1`.
- Back-to-back glyphs: `pop` is high at cycle t. With `fb_ready` tied high, the glyph's last DRAW cycle is t+1+GLYPH_H·(GLYPH_W+2), i.e. t+81 at defaults. The next `pop` can be at t+82.
- Each `fb_ready` stall adds exactly one cycle.
- ROM read latency: exactly one cycle.
- Stack read latency: exactly one cycle.
- Framebuffer writes are issued in raster order within a glyph.

## Structure
- Shared package `glyph_pkg`:
  - width parameters: CHAR_ID/X/Y/COLOR/FB_ADDR
  - GLYPH_W, GLYPH_H, SCREEN_W, SCREEN_H
  - the FSM state enum
  - the derived ROM address width
- One sub-module, `fb_address_gen`:
  - combinational
  - computes `x+col` and `y+row`, the in-bounds flag, and `fb_addr`
  - uses one constant multiply by SCREEN_W, which synthesises to shift-add at 320 = 256+64.
- The FSM, the row/col counters and the shifter stay in `glyph_blitter`.

## Test plan
- **Single glyph:** stack holds (id=0x41, x=10, y=20); ROM row 0 = 0x81, other rows 0x00; `fb_ready=1`.
  - Exactly 2 writes: addr 20·320+10 = 6410 and 6417, data = `fg_color`.
  - `idle` returns high 82 cycles after `pop`.
- **Clipping:** (x=316, y=236), every row = 0xFF.
  - Exactly 16 writes: cols 316–319 on rows 236–239.
  - No write with x ≥ 320 or y ≥ 240.
- **Backpressure:** same stimulus as the single-glyph test, with `fb_ready` low for 3 cycles during the first write.
  - `fb_we`, `fb_addr=6410` and `fb_data` hold stable for 3 extra cycles.
  - Total duration grows by 3.
- **Empty/enable:**
  - `empty=1` for 100 cycles: `pop` never asserts.
  - `enable` dropped mid-glyph with 2 entries queued: the first glyph completes and the second is not popped.
- **Back-to-back:** 3 entries queued.
  - `pop` pulses are exactly 82 cycles apart.
  - Each glyph's writes use its own id and coordinates.
- **Reset mid-DRAW:** `reset_n` low for one cycle at row 3.
  - The next cycle shows `fb_we=0` and `idle=1`.
  - No further writes from that glyph.
  - With the stack non-empty, the next `pop` follows one cycle after reset release.
